ibfu_iter: RTL and testbench
============================

IBFU_ITER -- requirements
Module: ibfu_iter

Interface
REQ-001 Parameter Q, default 32'hFFFFFFFB; odd prime modulus, Q < 2^(`Datawidth+1).
REQ-002 Parameter HALVE, default 0; when 1, both outputs are multiplied by 2^-1 mod Q (inverse-NTT scaling).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 xin  input  [`Datawidth:0]  upper butterfly operand; values < Q.
REQ-006 yin  input  [`Datawidth:0]  lower butterfly operand; values < Q.
REQ-007 wr  input  [`Datawidth:0]  inverse twiddle factor; values < Q.
REQ-008 en  input  1  start request, sampled only when idle.
REQ-009 xout  output  [`Datawidth:0]  (xin+yin) mod Q, optionally halved.
REQ-010 yout  output  [`Datawidth:0]  ((xin-yin)*wr) mod Q, optionally halved.
REQ-011 valid  output  1  one-cycle pulse marking new xout/yout.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Block is the Gentleman-Sande (inverse) counterpart of the Cooley-Tukey bfu, computed iteratively; W = `Datawidth+1.
REQ-014 FSM states IDLE, ADD, MUL, HALF; HALF is reachable only when HALVE=1.
REQ-015 IDLE: on en=1 latch xin, yin, wr into internal registers and go to ADD; en=0 stays IDLE.
REQ-016 ADD, one cycle: s = (x+y) mod Q; d = (x-y) mod Q (add Q on borrow); acc = 0; bit counter = W-1; go to MUL.
REQ-017 MUL, exactly W cycles, MSB-first over wr: acc = (2*acc) mod Q, then if wr[cnt] acc = (acc+d) mod Q; cnt decrements.
REQ-018 All intermediate sums are computed W+1 bits wide; each reduction is a single conditional subtraction of Q.
REQ-019 Final MUL cycle with HALVE=0: xout<=s, yout<=acc_next, valid<=1, go to IDLE.
REQ-020 Final MUL cycle with HALVE=1: go to HALF. HALF: each of s and acc becomes v>>1 if v is even, else (v+Q)>>1; results go to xout/yout; valid<=1; go to IDLE.
REQ-021 Latency: valid is high in the cycle following accept edge + W+1 edges (HALVE=0) or + W+2 edges (HALVE=1).
REQ-022 valid is high for exactly one cycle per accepted request and is 0 at all other times.
REQ-023 xout/yout hold their last result until the next valid pulse.
REQ-024 en while busy=1 is ignored and not queued.
REQ-025 en=1 in the cycle that valid is high is accepted, because state is IDLE in that cycle. Back-to-back period is W+2 cycles (HALVE=0) or W+3 cycles (HALVE=1).
REQ-026 Operands >= Q produce an unspecified result, but the FSM timing is unchanged.

Reset
REQ-027 reset=1 at a clock edge forces state IDLE, xout=0, yout=0, valid=0, busy=0, acc=0 and counter=0, regardless of the current state.
REQ-028 Reset has priority over en. An operation in flight when reset is applied is discarded and produces no valid pulse.

Structure
REQ-029 Width comes from `Datawidth in define.v. A shared package/include holds the FSM state encoding (2 bits) and the default Q.
REQ-030 One combinational sub-module, mod_addsub (a+b mod Q, a-b mod Q), is instantiated for ADD and for each MUL step.
REQ-031 The FSM, counter and all registers reside in ibfu_iter; no multiplier primitive is inferred.

Verification (bench overrides Q=17)
REQ-032 HALVE=0, xin=5, yin=3, wr=4, en pulse -> valid exactly W+1 edges after accept, xout=8, yout=8, busy low afterwards.
REQ-033 HALVE=0 wrap cases:
- xin=3, yin=5, wr=2 -> xout=8, yout=13.
- xin=16, yin=16, wr=1 -> xout=15, yout=0.
- xin=0, yin=1, wr=16 -> yout=1.
REQ-034 HALVE=1 round trip: xin=0, yin=10, wr=13 -> xout=5, yout=3, valid W+2 edges after accept. Odd halving: xin=16, yin=16 -> xout=16.
REQ-035 en held high continuously -> valid pulses every W+2 cycles (HALVE=0). en toggled while busy -> no extra pulses and no corruption of the current result.
REQ-036 reset asserted mid-MUL for one cycle -> outputs 0, no valid pulse. The next request completes correctly with full latency.

Source files
------------

// File: rtl/ibfu_iter_pkg.sv
// Shared width, default modulus, FSM encoding and halving helper for the
// iterative Gentleman-Sande butterfly.
`ifndef Datawidth
`define Datawidth 31
`endif

package ibfu_iter_pkg;

  localparam int W  = `Datawidth + 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [W-1:0] Q_DEFAULT = W'(32'hFFFFFFFB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_HALF = 2'd3;

  // v * 2^-1 mod q for odd q: odd values borrow one q so the shift is exact.
  function automatic logic [W-1:0] halve_mod(input logic [W-1:0] v,
                                             input logic [W-1:0] q);
    logic [W:0] t;
    t = v[0] ? ({1'b0, v} + {1'b0, q}) : {1'b0, v};
    return W'(t >> 1);
  endfunction

endpackage

// File: rtl/ibfu_iter_mod_addsub.sv
// Modular add and subtract of two residues; each result needs at most one
// correction by Q, done on a W+1 bit intermediate.
module mod_addsub
  import ibfu_iter_pkg::*;
#(
  parameter logic [W-1:0] Q = Q_DEFAULT
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] diff_o
);

  logic [W:0] sum_w;
  logic [W:0] diff_w;

  always_comb begin
    sum_w  = {1'b0, a_i} + {1'b0, b_i};
    diff_w = {1'b0, a_i} - {1'b0, b_i};
    sum_o  = (sum_w >= {1'b0, Q}) ? W'(sum_w - {1'b0, Q}) : W'(sum_w);
    // diff_w[W] is the borrow out of the subtraction
    diff_o = diff_w[W] ? W'(diff_w + {1'b0, Q}) : W'(diff_w);
  end

endmodule

// File: rtl/ibfu_iter.sv
// Iterative inverse (Gentleman-Sande) butterfly: xout = x+y, yout = (x-y)*wr,
// mod Q, with the product formed by MSB-first double-and-add over wr.
module ibfu_iter
  import ibfu_iter_pkg::*;
#(
  parameter logic [W-1:0] Q     = Q_DEFAULT,
  parameter int           HALVE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [`Datawidth:0] xin,
  input  logic [`Datawidth:0] yin,
  input  logic [`Datawidth:0] wr,
  input  logic              en,
  output logic [`Datawidth:0] xout,
  output logic [`Datawidth:0] yout,
  output logic              valid,
  output logic              busy
);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d, w_q, w_d;
  logic [W-1:0]  s_q, s_d, d_q, d_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  xout_q, xout_d, yout_q, yout_d;
  logic          valid_q, valid_d;

  logic [W-1:0] ua_a, ua_b, ua_sum, ua_diff;
  logic [W-1:0] ub_sum, unused_diff;
  logic [W-1:0] acc_nx;

  // In ADD the first unit forms x+y / x-y; in MUL it doubles the accumulator.
  assign ua_a = (state_q == S_ADD) ? x_q : acc_q;
  assign ua_b = (state_q == S_ADD) ? y_q : acc_q;

  mod_addsub #(.Q(Q)) u_first (
    .a_i   (ua_a),
    .b_i   (ua_b),
    .sum_o (ua_sum),
    .diff_o(ua_diff)
  );

  mod_addsub #(.Q(Q)) u_step (
    .a_i   (ua_sum),
    .b_i   (d_q),
    .sum_o (ub_sum),
    .diff_o(unused_diff)
  );

  assign acc_nx = w_q[cnt_q] ? ub_sum : ua_sum;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    s_d     = s_q;
    d_d     = d_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    xout_d  = xout_q;
    yout_d  = yout_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          x_d     = xin;
          y_d     = yin;
          w_d     = wr;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        s_d     = ua_sum;
        d_d     = ua_diff;
        acc_d   = '0;
        cnt_d   = CW'(W - 1);
        state_d = S_MUL;
      end
      S_MUL: begin
        acc_d = acc_nx;
        if (cnt_q == '0) begin
          if (HALVE != 0) begin
            state_d = S_HALF;
          end else begin
            xout_d  = s_q;
            yout_d  = acc_nx;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HALF: begin
        xout_d  = halve_mod(s_q, Q);
        yout_d  = halve_mod(acc_q, Q);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      s_q     <= '0;
      d_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      xout_q  <= '0;
      yout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      s_q     <= s_d;
      d_q     <= d_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      xout_q  <= xout_d;
      yout_q  <= yout_d;
      valid_q <= valid_d;
    end
  end

  assign xout  = xout_q;
  assign yout  = yout_q;
  assign valid = valid_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_ibfu_iter.sv
// Bench for ibfu_iter with Q=17: one HALVE=0 and one HALVE=1 instance, checked
// every cycle against an arithmetic model plus directed literal expectations.
`ifndef Datawidth
`define Datawidth 31
`endif

module tb_ibfu_iter;

  localparam int W  = `Datawidth + 1;
  localparam int QV = 17;
  localparam int INV2 = 9;   // 2*9 = 18 = 1 mod 17

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] xin [2];
  logic [W-1:0] yin [2];
  logic [W-1:0] wr  [2];
  logic [W-1:0] xout[2];
  logic [W-1:0] yout[2];
  logic en[2], valid[2], busy[2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ibfu_iter #(.Q(17), .HALVE(0)) u_d0 (
    .clk(clk), .reset(reset), .xin(xin[0]), .yin(yin[0]), .wr(wr[0]), .en(en[0]),
    .xout(xout[0]), .yout(yout[0]), .valid(valid[0]), .busy(busy[0]));

  ibfu_iter #(.Q(17), .HALVE(1)) u_d1 (
    .clk(clk), .reset(reset), .xin(xin[1]), .yin(yin[1]), .wr(wr[1]), .en(en[1]),
    .xout(xout[1]), .yout(yout[1]), .valid(valid[1]), .busy(busy[1]));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic longint fx(input longint x, input longint y, input int h);
    longint s = (x + y) % QV;
    return (h != 0) ? (s * INV2) % QV : s;
  endfunction

  function automatic longint fy(input longint x, input longint y, input longint w,
                                input int h);
    longint p = (((x + QV - y) % QV) * w) % QV;
    return (h != 0) ? (p * INV2) % QV : p;
  endfunction

  // Model: one pending request per instance, result due W+1(+HALVE) edges after accept.
  int     edge_n = 0;
  bit     armed = 1'b0;
  bit     pend[2];
  int     due[2];
  longint nx[2], ny[2], ex[2], ey[2];
  bit     ev[2];

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (reset) armed <= 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        pend[d] <= 1'b0;
        ev[d]   <= 1'b0;
        ex[d]   <= 0;
        ey[d]   <= 0;
      end else begin
        ev[d] <= pend[d] && (edge_n == due[d]);
        if (pend[d] && edge_n == due[d]) begin
          ex[d]   <= nx[d];
          ey[d]   <= ny[d];
          pend[d] <= 1'b0;
        end else if (!pend[d] && en[d]) begin
          pend[d] <= 1'b1;
          due[d]  <= edge_n + W + 1 + d;
          nx[d]   <= fx(longint'(xin[d]), longint'(yin[d]), d);
          ny[d]   <= fy(longint'(xin[d]), longint'(yin[d]), longint'(wr[d]), d);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("m_valid%0d", d), longint'(valid[d]), longint'(ev[d]));
        chk($sformatf("m_busy%0d", d), longint'(busy[d]), longint'(pend[d]));
        chk($sformatf("m_xout%0d", d), longint'(xout[d]), ex[d]);
        chk($sformatf("m_yout%0d", d), longint'(yout[d]), ey[d]);
      end
    end
  end

  task automatic wait_vld(input int d, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!valid[d] && n < 100);
    if (!valid[d]) chk("valid_timeout", 0, 1);
  endtask

  task automatic run_req(input int d, input longint x, input longint y, input longint w,
                         input longint exp_x, input longint exp_y);
    int n;
    @(negedge clk);
    xin[d] = W'(x); yin[d] = W'(y); wr[d] = W'(w); en[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en[d] = 1'b0;
    wait_vld(d, n);
    chk($sformatf("latency%0d", d), n, W + 1 + d);
    chk($sformatf("xout%0d_%0d_%0d", d, x, y), longint'(xout[d]), exp_x);
    chk($sformatf("yout%0d_%0d_%0d", d, x, y), longint'(yout[d]), exp_y);
    @(negedge clk);
    chk("busy_after", longint'(busy[d]), 0);
    chk("valid_one_cycle", longint'(valid[d]), 0);
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      xin[d] = '0; yin[d] = '0; wr[d] = '0; en[d] = 1'b0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_xout", longint'(xout[0]), 0);
    chk("rst_yout", longint'(yout[0]), 0);
    chk("rst_valid", longint'(valid[0]), 0);
    chk("rst_busy", longint'(busy[1]), 0);
    reset = 1'b0;

    run_req(0, 5, 3, 4, 8, 8);
    run_req(0, 3, 5, 2, 8, 13);
    run_req(0, 16, 16, 1, 15, 0);
    run_req(0, 0, 1, 16, 1, 1);
    run_req(1, 0, 10, 13, 5, 3);
    run_req(1, 16, 16, 1, 16, 0);

    // en held high: back-to-back pulses every W+2 cycles
    @(negedge clk);
    xin[0] = W'(7); yin[0] = W'(2); wr[0] = W'(3); en[0] = 1'b1;
    wait_vld(0, n);
    chk("held_xout", longint'(xout[0]), 9);
    chk("held_yout", longint'(yout[0]), 15);
    wait_vld(0, n);
    chk("held_period1", n, W + 2);
    wait_vld(0, n);
    chk("held_period2", n, W + 2);
    en[0] = 1'b0;
    repeat (3) @(negedge clk);

    // en toggled while busy must be ignored
    @(negedge clk);
    xin[0] = W'(9); yin[0] = W'(4); wr[0] = W'(5); en[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      en[0] = ~en[0];
      xin[0] = W'(i % QV); yin[0] = W'((i * 3) % QV); wr[0] = W'((i * 5) % QV);
      @(negedge clk);
    end
    en[0] = 1'b0;
    wait_vld(0, n);
    chk("toggle_xout", longint'(xout[0]), 13);
    chk("toggle_yout", longint'(yout[0]), 8);
    repeat (40) @(negedge clk);

    // reset mid-MUL discards the operation
    @(negedge clk);
    xin[0] = W'(2); yin[0] = W'(1); wr[0] = W'(3); en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_xout", longint'(xout[0]), 0);
    chk("midrst_yout", longint'(yout[0]), 0);
    chk("midrst_valid", longint'(valid[0]), 0);
    chk("midrst_busy", longint'(busy[0]), 0);
    repeat (40) @(negedge clk);
    run_req(0, 4, 9, 7, 13, 16);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
